// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: state encoding and latency limits.
package mac_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 8;

  function automatic bit mul_lat_legal(input int lat);
    return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
  endfunction

endpackage

// File: rtl/mac_sequencer_token_pipe.sv
// Token shift register that tracks operand pairs through the multiplier
// pipeline. out is the token leaving the pipe. last_token flags that only the
// oldest slot holds a token, i.e. the accumulate now leaving is the final one.
module mac_sequencer_token_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic token_in,
  output logic token_out,
  output logic last_token
);

  localparam logic [DEPTH-1:0] MSB_ONLY = DEPTH'(1) << (DEPTH - 1);

  logic [DEPTH-1:0] pipe;

  // A single-stage pipe has no lower bits to shift, so it gets its own form.
  if (DEPTH == 1) begin : g_single
    // Capture the newest token; flush discards it.
    always_ff @(posedge clk) begin
      if (rst || flush) pipe <= '0;
      else              pipe <= token_in;
    end
  end else begin : g_multi
    // Shift tokens toward the MSB; flush discards everything in flight.
    always_ff @(posedge clk) begin
      if (rst || flush) pipe <= '0;
      else              pipe <= {pipe[DEPTH-2:0], token_in};
    end
  end

  assign token_out  = pipe[DEPTH-1];
  assign last_token = (pipe == MSB_ONLY);

endmodule

// File: rtl/mac_sequencer.sv
// Control FSM for the MAC datapath. Accepts operand pairs, pulses the operand
// load and accumulator clear/enable strobes, and hands off the finished result.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | accumulator cleared this cycle
// RUN   | accepting operand pairs
// DRAIN | all pairs taken, waiting for the multiplier to empty
// HOLD  | result valid, waiting for out_ready
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_ab,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  if (!mul_lat_legal(MUL_LAT)) begin : g_bad_mul_lat
    $error("mac_sequencer: MUL_LAT must be within 1..8");
  end

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             accept;
  logic             cancel;
  logic             last_token;

  assign accept  = in_valid & in_ready;
  assign load_ab = accept;
  // abort only means something once a vector is underway.
  assign cancel  = abort && (state != ST_IDLE);

  mac_sequencer_token_pipe #(
    .DEPTH(MUL_LAT)
  ) u_token_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (cancel),
    .token_in  (accept),
    .token_out (acc_en),
    .last_token(last_token)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and state-derived strobes.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    acc_clr   = 1'b0;
    out_valid = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        acc_clr   = 1'b1;
        state_nxt = (remaining != '0) ? ST_RUN : ST_HOLD;
      end
      ST_RUN: begin
        // Gating on remaining keeps the counter from ever wrapping.
        in_ready = (remaining != '0);
        if (accept && (remaining == LEN_W'(1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_token) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (cancel) state_nxt = ST_IDLE;
  end

  // Pairs still to accept in the current vector.
  always_ff @(posedge clk) begin
    if (rst || cancel)                    remaining <= '0;
    else if ((state == ST_IDLE) && start) remaining <= len;
    else if (accept)                      remaining <= remaining - LEN_W'(1);
  end

  // One-cycle completion pulse following the result handshake.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= (state == ST_HOLD) && out_ready && !abort;
  end

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid, out_ready;
  logic [3:0] len;
  logic [2:0] in_ready_o, load_o, clr_o, acc_o, ov_o, busy_o, done_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit armed    = 0;

  int lat [3] = '{1, 2, 4};

  // behavioural model state, one entry per DUT latency
  bit m_active [3];
  bit m_len0   [3];
  bit m_done   [3];
  int m_start  [3];
  int m_need   [3];
  int m_last   [3];
  int dueq     [3][$];

  logic ex_busy, ex_clr, ex_rdy, ex_load, ex_acc, ex_ov, nd;
  int   ready_at;

  logic [11:0] t2_load, t2_clr;
  logic [11:0] t2_acc [3];
  logic [11:0] t2_ov  [3];
  logic [11:0] t2_done[3];

  always #5 clk = ~clk;

  mac_sequencer #(.LEN_W(4), .MUL_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_o[0]), .load_ab(load_o[0]),
    .acc_clr(clr_o[0]), .acc_en(acc_o[0]), .out_valid(ov_o[0]),
    .out_ready(out_ready), .busy(busy_o[0]), .done(done_o[0]));

  mac_sequencer #(.LEN_W(4), .MUL_LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_o[1]), .load_ab(load_o[1]),
    .acc_clr(clr_o[1]), .acc_en(acc_o[1]), .out_valid(ov_o[1]),
    .out_ready(out_ready), .busy(busy_o[1]), .done(done_o[1]));

  mac_sequencer #(.LEN_W(4), .MUL_LAT(4)) u_l4 (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_o[2]), .load_ab(load_o[2]),
    .acc_clr(clr_o[2]), .acc_en(acc_o[2]), .out_valid(ov_o[2]),
    .out_ready(out_ready), .busy(busy_o[2]), .done(done_o[2]));

  task automatic chk(input string nm, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s lat=%0d got=%0b want=%0b t=%0t", nm, lat[k], act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // start with len=3 and in_valid/out_ready held high; literal timing per latency
  task automatic run_t2();
    start = 1; len = 4'd3; in_valid = 1; out_ready = 1; abort = 0;
    for (int c = 1; c < 12; c++) begin
      next_cycle();
      start = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
        chk("t2_acc_clr", k, clr_o[k], t2_clr[c]);
        chk("t2_load_ab", k, load_o[k], t2_load[c]);
        chk("t2_acc_en", k, acc_o[k], t2_acc[k][c]);
        chk("t2_out_valid", k, ov_o[k], t2_ov[k][c]);
        chk("t2_done", k, done_o[k], t2_done[k][c]);
      end
    end
  endtask

  initial begin
    t2_clr     = 12'b0000_0000_0010;
    t2_load    = 12'b0000_0001_1100;
    t2_acc[0]  = 12'b0000_0011_1000;
    t2_acc[1]  = 12'b0000_0111_0000;
    t2_acc[2]  = 12'b0001_1100_0000;
    t2_ov[0]   = 12'b0000_0100_0000;
    t2_ov[1]   = 12'b0000_1000_0000;
    t2_ov[2]   = 12'b0010_0000_0000;
    t2_done[0] = 12'b0000_1000_0000;
    t2_done[1] = 12'b0001_0000_0000;
    t2_done[2] = 12'b0100_0000_0000;

    rst = 1; start = 1; len = 4'd3; abort = 0; in_valid = 1; out_ready = 0;

    // model and per-cycle comparison against the DUTs
    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          ex_busy  = m_active[k];
          ex_clr   = m_active[k] && (cyc == m_start[k] + 1);
          ex_rdy   = m_active[k] && (cyc > m_start[k] + 1) && (m_need[k] > 0);
          ex_load  = ex_rdy && in_valid;
          ex_acc   = (dueq[k].size() > 0) && (dueq[k][0] == cyc);
          ready_at = m_len0[k] ? m_start[k] + 2 : m_last[k] + lat[k] + 1;
          ex_ov    = m_active[k] && (m_need[k] == 0) && (cyc >= ready_at);
          if (armed) begin
            chk("m_busy", k, busy_o[k], ex_busy);
            chk("m_acc_clr", k, clr_o[k], ex_clr);
            chk("m_in_ready", k, in_ready_o[k], ex_rdy);
            chk("m_load_ab", k, load_o[k], ex_load);
            chk("m_acc_en", k, acc_o[k], ex_acc);
            chk("m_out_valid", k, ov_o[k], ex_ov);
            chk("m_done", k, done_o[k], m_done[k]);
          end
          if (rst) begin
            m_active[k] = 0;
            m_done[k]   = 0;
            dueq[k].delete();
          end else begin
            nd = 0;
            if (ex_acc) void'(dueq[k].pop_front());
            if (!m_active[k]) begin
              if (start) begin
                m_active[k] = 1;
                m_start[k]  = cyc;
                m_need[k]   = int'(len);
                m_len0[k]   = (len == 4'd0);
              end
            end else if (abort) begin
              m_active[k] = 0;
              dueq[k].delete();
            end else begin
              if (ex_load) begin
                m_need[k]--;
                m_last[k] = cyc;
                dueq[k].push_back(cyc + lat[k]);
              end
              if (ex_ov && out_ready) begin
                m_active[k] = 0;
                nd = 1;
              end
            end
            m_done[k] = nd;
          end
        end
        if (rst) armed = 1;
        cyc++;
      end
    join_none

    // reset with start held high: nothing may begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0; start = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, busy_o[k], 1'b0);
      chk("rst_in_ready", k, in_ready_o[k], 1'b0);
      chk("rst_out_valid", k, ov_o[k], 1'b0);
      chk("rst_acc_en", k, acc_o[k], 1'b0);
      chk("rst_done", k, done_o[k], 1'b0);
    end
    next_cycle();

    run_t2();

    // zero-length vector, result held 10+ cycles while start keeps pulsing
    start = 1; len = 4'd0; in_valid = 1; out_ready = 0;
    for (int c = 1; c < 15; c++) begin
      next_cycle();
      if (c == 12) begin start = 0; out_ready = 1; end
      #1;
      for (int k = 0; k < 3; k++) begin
        chk("t4_acc_clr", k, clr_o[k], c == 1);
        chk("t4_out_valid", k, ov_o[k], c >= 2 && c <= 12);
        chk("t4_in_ready", k, in_ready_o[k], 1'b0);
        chk("t4_acc_en", k, acc_o[k], 1'b0);
        chk("t4_done", k, done_o[k], c == 13);
      end
    end
    out_ready = 0;

    // abort after two accepts
    start = 1; len = 4'd5; in_valid = 1;
    for (int c = 1; c < 13; c++) begin
      next_cycle();
      start = 0;
      if (c == 4) begin abort = 1; in_valid = 0; end
      if (c == 5) abort = 0;
      #1;
      if (c >= 5) begin
        for (int k = 0; k < 3; k++) begin
          chk("t5_busy", k, busy_o[k], 1'b0);
          chk("t5_acc_en", k, acc_o[k], 1'b0);
          chk("t5_done", k, done_o[k], 1'b0);
        end
      end
    end

    run_t2();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      rst       = ($urandom_range(0, 599) == 0);
      start     = ($urandom_range(0, 3) == 0);
      len       = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      abort     = ($urandom_range(0, 79) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
    end
    next_cycle();
    rst = 0; start = 0; abort = 0;
    repeat (3) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
